// File: rtl/calc_key_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer_if
// Bundle between the keypad source, the calculator key sequencer and the
// combinational ALU it feeds.
//
// Key handshake: the source raises key_valid with key_code and holds both
// stable until a rising clock edge where key_valid && key_ready; that edge
// consumes the key. key_ready does not depend on key_valid.
//
// Signals:
//   key_valid, key_code   keypad source -> sequencer
//   key_ready             sequencer -> keypad source
//   alu_a, alu_b, alu_op  sequencer -> ALU operands / opcode
//   alu_r                 ALU -> sequencer result
//   disp_value            value to display
//   result_valid          one-cycle pulse when a result is latched
//   error                 sticky error flag
//   state_dbg             current sequencer state (debug visibility)
//
// Modports: slave = sequencer view, master = environment (keypad + ALU) view.
// -----------------------------------------------------------------------------
interface calc_key_sequencer_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_op;
    logic [15:0] alu_r;
    logic [15:0] disp_value;
    logic        result_valid;
    logic        error;
    logic [2:0]  state_dbg;

    modport slave (
        input  key_valid, key_code, alu_r,
        output key_ready, alu_a, alu_b, alu_op, disp_value,
               result_valid, error, state_dbg
    );

    modport master (
        output key_valid, key_code, alu_r,
        input  key_ready, alu_a, alu_b, alu_op, disp_value,
               result_valid, error, state_dbg
    );
endinterface

// File: rtl/calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer
// Sequential front-end for the combinational calculator ALU. Builds decimal
// operands A and B from keypad digits, captures the operator, and on '='
// holds the ALU inputs stable for EXEC_WAIT cycles before latching alu_r as
// the new A / display value. Results can be chained with further operators
// or the last operation repeated with another '='.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    calc_key_sequencer_if.slave (key handshake, ALU a/b/op/r,
//          disp_value, result_valid, error, state_dbg)
//
// Key codes: 0-9 digit, 10 clear, 11 add, 12 sub, 13 mult, 14 div, 15 equals.
//
// Parameters:
//   MAX_DIGITS  digits accepted per operand (extra digits ignored)
//   EXEC_WAIT   cycles the ALU inputs are held before alu_r is sampled (1..15)
//
// Optional feature macro: DIV_ZERO_CHECK_EN
//   When defined, '=' with opcode 14 and B == 0 enters ERR (error set,
//   display 16'hFFFF) instead of executing. When undefined, the division is
//   executed and whatever the ALU returns is latched.
// -----------------------------------------------------------------------------
module calc_key_sequencer #(
    parameter int MAX_DIGITS = 5,
    parameter int EXEC_WAIT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc_key_sequencer_if.slave  bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        EXEC    = 3'd2,
        SHOW    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t        state, next_state;
    logic [15:0]   a_q, b_q, op_q, disp_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    wait_q;
    logic          rv_q, err_q;

    logic          key_ready, accept;
    logic          is_digit, is_clear, is_op, is_eq;
    logic          digit_ok, div_zero;
    logic [15:0]   operand;
    logic [19:0]   acc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ENTER_A;
        else        state <= next_state;
    end

    // Next-state logic; a clear key can only be accepted outside EXEC
    always_comb begin
        next_state = state;
        if (accept && is_clear) begin
            next_state = ENTER_A;
        end else begin
            unique case (state)
                ENTER_A: if (accept && is_op) next_state = ENTER_B;
                ENTER_B: if (accept && is_eq) next_state = div_zero ? ERR : EXEC;
                EXEC:    if (wait_q == 4'd0)  next_state = SHOW;
                SHOW: begin
                    if (accept) begin
                        if (is_op)         next_state = ENTER_B;
                        else if (is_digit) next_state = ENTER_A;
                        else if (is_eq)    next_state = div_zero ? ERR : EXEC;
                    end
                end
                ERR:     next_state = ERR;
                default: next_state = ENTER_A;
            endcase
        end
    end

    // Output / decode logic
    always_comb begin
        key_ready = (state != EXEC);
        accept    = bus.key_valid && key_ready;
        is_digit  = (bus.key_code <= 4'd9);
        is_clear  = (bus.key_code == 4'd10);
        is_eq     = (bus.key_code == 4'd15);
        is_op     = !is_digit && !is_clear && !is_eq;
        // Digit accumulation is evaluated wide so an overflowing digit can be rejected
        operand   = (state == ENTER_B) ? b_q : a_q;
        acc       = {4'b0, operand} * 20'd10 + {16'b0, bus.key_code};
        digit_ok  = (cnt_q != CW'(MAX_DIGITS)) && (acc <= 20'd65535);
`ifdef DIV_ZERO_CHECK_EN
        div_zero  = (op_q == 16'd14) && (b_q == 16'd0);
`else
        div_zero  = 1'b0;
`endif
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= 16'd0;
            b_q    <= 16'd0;
            op_q   <= 16'd11;
            disp_q <= 16'd0;
            cnt_q  <= '0;
            wait_q <= 4'd0;
            rv_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            if (accept && is_clear) begin
                a_q    <= 16'd0;
                b_q    <= 16'd0;
                op_q   <= 16'd11;
                disp_q <= 16'd0;
                cnt_q  <= '0;
                wait_q <= 4'd0;
                err_q  <= 1'b0;
            end else begin
                unique case (state)
                    ENTER_A: begin
                        if (accept && is_digit && digit_ok) begin
                            a_q    <= acc[15:0];
                            disp_q <= acc[15:0];
                            cnt_q  <= cnt_q + 1'b1;
                        end else if (accept && is_op) begin
                            op_q  <= {12'b0, bus.key_code};
                            b_q   <= 16'd0;
                            cnt_q <= '0;
                        end
                    end
                    ENTER_B: begin
                        if (accept && is_digit && digit_ok) begin
                            b_q    <= acc[15:0];
                            disp_q <= acc[15:0];
                            cnt_q  <= cnt_q + 1'b1;
                        end else if (accept && is_op) begin
                            op_q <= {12'b0, bus.key_code};
                        end else if (accept && is_eq) begin
                            if (div_zero) begin
                                err_q  <= 1'b1;
                                disp_q <= 16'hFFFF;
                            end else begin
                                wait_q <= 4'(EXEC_WAIT);
                            end
                        end
                    end
                    EXEC: begin
                        // ALU inputs have been stable for EXEC_WAIT cycles by now
                        if (wait_q == 4'd0) begin
                            a_q    <= bus.alu_r;
                            disp_q <= bus.alu_r;
                            rv_q   <= 1'b1;
                        end else begin
                            wait_q <= wait_q - 4'd1;
                        end
                    end
                    SHOW: begin
                        if (accept && is_op) begin
                            op_q  <= {12'b0, bus.key_code};
                            b_q   <= 16'd0;
                            cnt_q <= '0;
                        end else if (accept && is_digit) begin
                            a_q    <= {12'b0, bus.key_code};
                            disp_q <= {12'b0, bus.key_code};
                            cnt_q  <= CW'(1);
                        end else if (accept && is_eq) begin
                            if (div_zero) begin
                                err_q  <= 1'b1;
                                disp_q <= 16'hFFFF;
                            end else begin
                                wait_q <= 4'(EXEC_WAIT);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.key_ready    = key_ready;
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_op       = op_q;
    assign bus.disp_value   = disp_q;
    assign bus.result_valid = rv_q;
    assign bus.error        = err_q;
    assign bus.state_dbg    = state;

endmodule
